// File: rtl/pipe_fwd_scoreboard.sv
// Forwarding and load-use hazard unit with a shift-register scoreboard.
// Ports: clk/reset; dec_* decode-stage operands and destination; flush
//   squashes decode; stage_result packs per-stage results (stage k at
//   slice k-1); stall holds decode; fwd_* resolved operands and sources;
//   stall_count saturating stall-cycle counter.
module pipe_fwd_scoreboard #(
  parameter int WIDTH      = 32,
  parameter int NREGS      = 32,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2,
  parameter int CNT_W      = 16,
  localparam int AW        = $clog2(NREGS),
  localparam int SW        = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dec_valid,
  input  logic [AW-1:0]          dec_rs,
  input  logic [AW-1:0]          dec_rt,
  input  logic [WIDTH-1:0]       dec_rs_data,
  input  logic [WIDTH-1:0]       dec_rt_data,
  input  logic [AW-1:0]          dec_aw,
  input  logic                   dec_wr_en,
  input  logic                   dec_is_load,
  input  logic                   flush,
  input  logic [WIDTH*DEPTH-1:0] stage_result,
  output logic                   stall,
  output logic [WIDTH-1:0]       fwd_rs_data,
  output logic [WIDTH-1:0]       fwd_rt_data,
  output logic [SW-1:0]          fwd_rs_sel,
  output logic [SW-1:0]          fwd_rt_sel,
  output logic [CNT_W-1:0]       stall_count
);

  logic          r_v  [1:DEPTH];
  logic [AW-1:0] r_aw [1:DEPTH];
  logic          r_we [1:DEPTH];
  logic          r_ld [1:DEPTH];
  logic [CNT_W-1:0] r_cnt;

  logic [AW-1:0]    w_src  [2];
  logic [WIDTH-1:0] w_rf   [2];
  logic [WIDTH-1:0] w_data [2];
  logic [SW-1:0]    w_sel  [2];
  logic             w_haz  [2];
  logic             w_stall;

  assign w_src[0] = dec_rs;
  assign w_src[1] = dec_rt;
  assign w_rf[0]  = dec_rs_data;
  assign w_rf[1]  = dec_rt_data;

  // Oldest-to-youngest scan: the last hit assigned is the youngest.
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      w_data[j] = w_rf[j];
      w_sel[j]  = '0;
      w_haz[j]  = 1'b0;
      for (int k = DEPTH; k >= 1; k--) begin
        if (!reset && r_v[k] && r_we[k] &&
            r_aw[k] == w_src[j] && w_src[j] != '0) begin
          w_data[j] = stage_result[(k-1)*WIDTH +: WIDTH];
          w_sel[j]  = SW'(k);
          w_haz[j]  = r_ld[k] && (k < LOAD_READY);
        end
      end
    end
  end

  assign w_stall = dec_valid && !flush && !reset &&
                   (w_haz[0] || w_haz[1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= DEPTH; k++) begin
        r_v[k]  <= 1'b0;
        r_aw[k] <= '0;
        r_we[k] <= 1'b0;
        r_ld[k] <= 1'b0;
      end
      r_cnt <= '0;
    end else begin
      r_v[1]  <= dec_valid && !flush && !w_stall;
      r_aw[1] <= dec_aw;
      r_we[1] <= dec_wr_en;
      r_ld[1] <= dec_is_load;
      for (int k = 2; k <= DEPTH; k++) begin
        r_v[k]  <= r_v[k-1];
        r_aw[k] <= r_aw[k-1];
        r_we[k] <= r_we[k-1];
        r_ld[k] <= r_ld[k-1];
      end
      if (w_stall && r_cnt != '1)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign stall       = w_stall;
  assign fwd_rs_data = w_data[0];
  assign fwd_rt_data = w_data[1];
  assign fwd_rs_sel  = w_sel[0];
  assign fwd_rt_sel  = w_sel[1];
  assign stall_count = r_cnt;

endmodule

// File: tb/tb_pipe_fwd_scoreboard.sv
// Directed bench for pipe_fwd_scoreboard (default and CNT_W=2 instances).
// Ports: none.
module tb_pipe_fwd_scoreboard;
  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid, dec_wr_en, dec_is_load, flush;
  logic [4:0]  dec_rs, dec_rt, dec_aw;
  logic [31:0] dec_rs_data, dec_rt_data;
  logic [95:0] stage_result;
  logic        stall, stall2;
  logic [31:0] fwd_rs_data, fwd_rt_data, rs2, rt2;
  logic [1:0]  fwd_rs_sel, fwd_rt_sel, rsel2, tsel2;
  logic [15:0] stall_count;
  logic [1:0]  cnt2;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] saved;

  always #5 clk = ~clk;

  pipe_fwd_scoreboard dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid),
    .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_rs_data(dec_rs_data), .dec_rt_data(dec_rt_data),
    .dec_aw(dec_aw), .dec_wr_en(dec_wr_en),
    .dec_is_load(dec_is_load), .flush(flush),
    .stage_result(stage_result), .stall(stall),
    .fwd_rs_data(fwd_rs_data), .fwd_rt_data(fwd_rt_data),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .stall_count(stall_count)
  );

  pipe_fwd_scoreboard #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .dec_valid(dec_valid),
    .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_rs_data(dec_rs_data), .dec_rt_data(dec_rt_data),
    .dec_aw(dec_aw), .dec_wr_en(dec_wr_en),
    .dec_is_load(dec_is_load), .flush(flush),
    .stage_result(stage_result), .stall(stall2),
    .fwd_rs_data(rs2), .fwd_rt_data(rt2),
    .fwd_rs_sel(rsel2), .fwd_rt_sel(tsel2),
    .stall_count(cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic dec(input logic v, input logic [4:0] rs,
                     input logic [4:0] rt, input logic [4:0] aw,
                     input logic we, input logic ld);
    dec_valid   = v;
    dec_rs      = rs;
    dec_rt      = rt;
    dec_aw      = aw;
    dec_wr_en   = we;
    dec_is_load = ld;
    dec_rs_data = 32'h1000 + 32'(rs);
    dec_rt_data = 32'h2000 + 32'(rt);
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    stage_result = {32'h0000_0033, 32'hDEAD_BEEF, 32'h0000_0005};
    dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick;
    tick;
    reset = 1'b0;
    dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("rst_cnt", 32'(stall_count), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);

    // 1: ALU forwarding through each stage
    dec(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    chk("t1_nohit_sel", 32'(fwd_rs_sel), 32'd0);
    tick;
    dec(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("t1_sel1", 32'(fwd_rs_sel), 32'd1);
    chk("t1_dat1", fwd_rs_data, 32'h0000_0005);
    chk("t1_nostall", 32'(stall), 32'd0);
    chk("t1_rt0", fwd_rt_data, 32'h2000);
    tick;
    dec(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("t1_sel2", 32'(fwd_rs_sel), 32'd2);
    chk("t1_dat2", fwd_rs_data, 32'hDEAD_BEEF);
    tick;
    dec(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("t1_sel3", 32'(fwd_rs_sel), 32'd3);
    chk("t1_dat3", fwd_rs_data, 32'h0000_0033);
    tick;
    dec(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("t1_sel_rf", 32'(fwd_rs_sel), 32'd0);
    chk("t1_dat_rf", fwd_rs_data, 32'h1003);
    tick;

    // 2: load-use single stall
    dec(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1);
    tick;
    dec(1'b1, 5'd4, 5'd0, 5'd9, 1'b1, 1'b0);
    chk("t2_stall", 32'(stall), 32'd1);
    chk("t2_sel_stall", 32'(fwd_rs_sel), 32'd1);
    tick;
    chk("t2_cnt", 32'(stall_count), 32'd1);
    chk("t2_stall_rel", 32'(stall), 32'd0);
    chk("t2_sel2", 32'(fwd_rs_sel), 32'd2);
    chk("t2_dat2", fwd_rs_data, 32'hDEAD_BEEF);
    tick;
    dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick;
    tick;
    tick;

    // 3: youngest writer wins, rs == rt
    stage_result = {32'h0000_0033, 32'h0000_0011, 32'h0000_0022};
    dec(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
    tick;
    dec(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
    tick;
    dec(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    chk("t3_rs_sel", 32'(fwd_rs_sel), 32'd1);
    chk("t3_rt_sel", 32'(fwd_rt_sel), 32'd1);
    chk("t3_rs_dat", fwd_rs_data, 32'h22);
    chk("t3_rt_dat", fwd_rt_data, 32'h22);
    tick;

    // 4: r0 never forwards; flush beats stall
    dec(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    tick;
    dec(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    dec_rs_data = 32'd0;
    #1;
    chk("t4_r0_sel", 32'(fwd_rs_sel), 32'd0);
    chk("t4_r0_dat", fwd_rs_data, 32'd0);
    chk("t4_r0_stall", 32'(stall), 32'd0);
    tick;
    dec(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1);
    tick;
    saved = stall_count;
    flush = 1'b1;
    dec(1'b1, 5'd6, 5'd0, 5'd7, 1'b1, 1'b1);
    chk("t4_flush_stall", 32'(stall), 32'd0);
    tick;
    flush = 1'b0;
    dec(1'b1, 5'd7, 5'd6, 5'd0, 1'b0, 1'b0);
    chk("t4_flush_cnt", 32'(stall_count), 32'(saved));
    chk("t4_bubble_sel", 32'(fwd_rs_sel), 32'd0);
    chk("t4_ld_sel", 32'(fwd_rt_sel), 32'd2);
    tick;

    // 5: reset mid-stall
    dec(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1);
    tick;
    dec(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0);
    chk("t5_stall", 32'(stall), 32'd1);
    reset = 1'b1;
    #1;
    chk("t5_rst_stall", 32'(stall), 32'd0);
    chk("t5_rst_sel", 32'(fwd_rs_sel), 32'd0);
    chk("t5_rst_dat", fwd_rs_data, 32'h1004);
    tick;
    reset = 1'b0;
    #1;
    chk("t5_post_rs", 32'(fwd_rs_sel), 32'd0);
    chk("t5_post_rt", 32'(fwd_rt_sel), 32'd0);
    chk("t5_post_stall", 32'(stall), 32'd0);
    chk("t5_post_cnt", 32'(stall_count), 32'd0);
    chk("t5_post_cnt2", 32'(cnt2), 32'd0);
    tick;

    // 6: saturation of a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      dec(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1);
      tick;
      dec(1'b1, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0);
      chk($sformatf("t6_stall%0d", i), 32'(stall2), 32'd1);
      tick;
      chk($sformatf("t6_cnt2_%0d", i), 32'(cnt2),
          (i < 2) ? 32'(i + 1) : 32'd3);
      chk($sformatf("t6_cnt_%0d", i), 32'(stall_count), 32'(i + 1));
      tick;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_fwd_scoreboard.md
Name: pipe_fwd_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the pipelined CPU. It generalises fixed two-stage forwarding to a configurable pipeline depth, width and register count.
- Tracks every in-flight register writer in a shift-register scoreboard. Resolves decode-stage operands from the youngest in-flight producer.
- Detects load-use hazards and raises a stall that inserts a bubble. Counts stall cycles for performance measurement.
- Sits between the decoder/regfile read and the EX-stage input registers.

Parameters:
WIDTH, 32, datapath word width
NREGS, 32, architectural register count; AW = clog2(NREGS)
DEPTH, 3, tracked stages after decode (1 = EX, DEPTH = WB)
LOAD_READY, 2, first stage index whose stage_result is valid for a load
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
dec_valid  in  1  decode stage holds a real instruction
dec_rs  in  AW  source A register
dec_rt  in  AW  source B register
dec_rs_data  in  WIDTH  regfile read of dec_rs
dec_rt_data  in  WIDTH  regfile read of dec_rt
dec_aw  in  AW  destination register
dec_wr_en  in  1  instruction writes dec_aw
dec_is_load  in  1  result arrives at stage LOAD_READY
flush  in  1  squash decode instruction (taken branch/jump)
stage_result  in  WIDTH*DEPTH  result currently produced by stage k, slice [k*WIDTH-1:(k-1)*WIDTH]
stall  out  1  hold PC and decode; bubble into EX
fwd_rs_data  out  WIDTH  resolved operand A
fwd_rt_data  out  WIDTH  resolved operand B
fwd_rs_sel  out  clog2(DEPTH+1)  source of A: 0 = regfile, k = stage k
fwd_rt_sel  out  clog2(DEPTH+1)  source of B
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:

Scoreboard entries:
- One entry per stage k = 1..DEPTH, with fields v, aw, we, ld.
- All outputs except stall_count are combinational from the scoreboard and current inputs.

Every rising edge, when reset = 0:
- Entries shift: entry[k+1] <= entry[k]. Entry DEPTH retires; the regfile write happens that cycle.
- entry[1] <= {dec_valid & ~flush & ~stall, dec_aw, dec_wr_en, dec_is_load}.
- A stall or flush therefore inserts a bubble (v = 0) into entry[1]. The decode instruction is held by the external pipeline.

Match and forwarding:
- Entry k matches source s when v & we & (aw == s) & (s != 0).
- Register 0 always reads the regfile value and never stalls.
- Youngest match (smallest k) wins. If there is no match: data = dec_*_data, sel = 0.
- Entry k is ready when ld = 0, or k >= LOAD_READY.
- If the youngest match is ready: data = stage_result slice k, sel = k.

Stall:
- stall = dec_valid & ~flush & ~reset & (youngest match for rs, or for rt, is not ready).
- During a stall the fwd outputs still show the youngest-match selection. Their values are don't-care to the consumer.
- A stall releases automatically once the load advances to stage LOAD_READY.
- Example with LOAD_READY = 2: a load immediately followed by a dependent instruction causes exactly one stall cycle.
- rs == rt hazards and simultaneous rs/rt hazards both produce a single stall.
- An older matching entry is never used while a younger one matches.

Flush:
- Flush has priority over stall: stall = 0, and a bubble enters.

stall_count:
- Increments by 1 on each edge where stall = 1.
- Saturates at 2^CNT_W - 1.

Reset:
- On an edge with reset = 1, all v <= 0 and stall_count <= 0.
- While reset is high: stall = 0, fwd_*_data = dec_*_data, fwd_*_sel = 0.
- Reset asserted mid-stall clears the hazard on the following cycle. No stale forwarding survives.

Test Plan:
1. Reset, then decode ADD r3 writes, next cycle decode SUB reads rs = r3 -> fwd_rs_sel = 1, fwd_rs_data = stage_result[1] (0x0000_0005); stall = 0. One cycle later, a reader of r3 -> sel = 2. Two cycles later -> sel = 3. Three cycles later -> sel = 0, regfile data.
2. LW r4, then dependent ADD rs = r4 -> stall = 1 for exactly 1 cycle. stall_count 0 -> 1. Next cycle fwd_rs_sel = 2, data = stage_result[2] (0xDEAD_BEEF).
3. Two writers to r5 in consecutive cycles (values 0x11 in stage 2, 0x22 in stage 1); reader of r5 with rs = rt = r5 -> both sel = 1, data = 0x22.
4. Writer to r0 followed by a reader of r0 -> sel = 0, data = dec_rs_data (0), no stall. Load to r6 followed by a reader of r6 with flush = 1 -> stall = 0, bubble inserted, stall_count unchanged.
5. Load-use stall active, reset asserted for 1 cycle -> stall = 0 during reset. Next cycle all sel = 0, stall_count = 0.
6. CNT_W = 2; force 5 consecutive load-use stalls -> stall_count reads 1, 2, 3, 3, 3.
